// File: rtl/gather_output_arbiter.sv
// Packet-level round-robin allocator for a gather node's single output.
// Locks the winning input until its TAIL flit fires; flits gated by credits.
module gather_output_arbiter #(
    parameter int N_IN = 4,
    parameter int BUF_DEPTH = 4,
    parameter int IDX_W = $clog2(N_IN),
    parameter int CRD_W = $clog2(BUF_DEPTH + 1),
    // BODY is any other non-zero code (2'b10); 2'b00 is unused
    parameter logic [1:0] HEAD = 2'b01,
    parameter logic [1:0] TAIL = 2'b11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_IN-1:0]   in_valid,
    input  logic [2*N_IN-1:0] in_flit_type,
    input  logic              outVCAvailable,
    input  logic              credit_upd,
    output logic              outVCAvailableReset,
    output logic [N_IN-1:0]   grant,
    output logic [IDX_W-1:0]  out_sel,
    output logic              flit_fire,
    output logic [1:0]        out_flit_type,
    output logic [CRD_W-1:0]  credits,
    output logic              credit_err
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [N_IN-1:0]  cand;
    logic [IDX_W-1:0] win;
    logic             found;
    logic [1:0]       own_type;
    logic             locked;
    logic             alloc;
    logic             tail_fire;

    function automatic int wrap(input int j);
        return (j >= N_IN) ? j - N_IN : j;
    endfunction

    assign locked = (state == LOCKED);
    assign own_type = in_flit_type[{owner, 1'b0} +: 2];

    // HEAD flits at a buffer head are the only allocation candidates
    always_comb begin
        cand = '0;
        for (int i = 0; i < N_IN; i++) begin
            cand[i] = in_valid[i] && (in_flit_type[2*i +: 2] == HEAD);
        end
    end

    // First candidate at or after the round-robin pointer wins
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (!found && cand[wrap(int'(rr_ptr) + k)]) begin
                found = 1'b1;
                win = IDX_W'(wrap(int'(rr_ptr) + k));
            end
        end
    end

    assign alloc = !locked && outVCAvailable && found;
    assign outVCAvailableReset = alloc;

    // Only the owner may be granted, and only when a credit is available
    always_comb begin
        grant = '0;
        if (locked) begin
            grant[owner] = in_valid[owner] && (credits != '0);
        end
    end

    assign flit_fire = |grant;
    assign tail_fire = flit_fire && (own_type == TAIL);
    assign out_sel = locked ? owner : '0;
    assign out_flit_type = locked ? own_type : 2'b00;

    // Allocation FSM: lock on allocation, release and advance pointer on TAIL
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (alloc) begin
                        owner <= win;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (tail_fire) begin
                        state <= IDLE;
                        if (owner == IDX_W'(N_IN - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= owner + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream credit counter; a return at full count is flagged sticky
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits    <= CRD_W'(BUF_DEPTH);
            credit_err <= 1'b0;
        end else if (flit_fire && !credit_upd) begin
            credits <= credits - CRD_W'(1);
        end else if (credit_upd && !flit_fire) begin
            if (credits == CRD_W'(BUF_DEPTH)) begin
                credit_err <= 1'b1;
            end else begin
                credits <= credits + CRD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gather_output_arbiter.sv
// Directed bench for gather_output_arbiter (N_IN=4, BUF_DEPTH=4).
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_gather_output_arbiter;

    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b10;
    localparam logic [1:0] T = 2'b11;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] in_valid = '0;
    logic [7:0] in_flit_type = '0;
    logic       outVCAvailable = 1'b1;
    logic       credit_upd = 1'b0;
    logic       ovr;
    logic [3:0] grant;
    logic [1:0] out_sel;
    logic       flit_fire;
    logic [1:0] out_flit_type;
    logic [2:0] credits;
    logic       credit_err;

    int total = 0;
    int fails = 0;

    gather_output_arbiter dut (
        .clk                 (clk),
        .rstn                (rstn),
        .in_valid            (in_valid),
        .in_flit_type        (in_flit_type),
        .outVCAvailable      (outVCAvailable),
        .credit_upd          (credit_upd),
        .outVCAvailableReset (ovr),
        .grant               (grant),
        .out_sel             (out_sel),
        .flit_fire           (flit_fire),
        .out_flit_type       (out_flit_type),
        .credits             (credits),
        .credit_err          (credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic v, input logic [1:0] t);
        in_valid[i] = v;
        in_flit_type[2*i +: 2] = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_fire", flit_fire, 0);
        chk("rst_credits", credits, 4);
        chk("rst_err", credit_err, 0);
        chk("rst_sel", out_sel, 0);
        rstn = 1'b1;
        tick();

        // 1: single requester, 3-flit packet
        put(0, 1, H);
        settle();
        chk("t1_alloc", ovr, 1);
        chk("t1_alloc_nofire", grant, 0);
        tick();
        settle();
        chk("t1_head", grant, 4'b0001);
        chk("t1_head_type", out_flit_type, H);
        tick();
        put(0, 1, B);
        settle();
        chk("t1_body", grant, 4'b0001);
        chk("t1_cr3", credits, 3);
        tick();
        put(0, 1, T);
        settle();
        chk("t1_tail", grant, 4'b0001);
        chk("t1_tail_type", out_flit_type, T);
        tick();
        put(0, 0, H);
        settle();
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_ovr", ovr, 0);
        chk("t1_cr1", credits, 1);

        // 2: reset for rr_ptr=0, then all four HEAD, 2-flit packets
        rstn = 1'b0;
        settle();
        chk("t2_rst_cr", credits, 4);
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) put(i, 1, H);
        for (int e = 0; e < 4; e++) begin
            credit_upd = 1'b0;
            settle();
            chk("t2_alloc", ovr, 1);
            chk("t2_alloc_nofire", grant, 0);
            tick();
            credit_upd = 1'b1;
            settle();
            chk("t2_head", grant, 4'b0001 << e);
            chk("t2_sel", out_sel, e);
            tick();
            put(e, 1, T);
            settle();
            chk("t2_tail", grant, 4'b0001 << e);
            chk("t2_tail_type", out_flit_type, T);
            tick();
            put(e, 0, H);
            credit_upd = 1'b0;
        end
        settle();
        chk("t2_cr", credits, 4);
        chk("t2_done_ovr", ovr, 0);

        // 3: 6-flit packet on in2 with credit stall
        put(2, 1, H);
        settle();
        chk("t3_alloc", ovr, 1);
        tick();
        settle();
        chk("t3_head", grant, 4'b0100);
        tick();
        put(2, 1, B);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_body", grant, 4'b0100);
            tick();
        end
        settle();
        chk("t3_stall", grant, 0);
        chk("t3_cr0", credits, 0);
        tick();
        settle();
        chk("t3_stall2", flit_fire, 0);
        credit_upd = 1'b1;
        settle();
        chk("t3_upd_nofire", flit_fire, 0);
        tick();
        credit_upd = 1'b0;
        settle();
        chk("t3_release", grant, 4'b0100);
        chk("t3_cr1", credits, 1);
        tick();
        put(2, 1, T);
        settle();
        chk("t3_stall3", grant, 0);
        credit_upd = 1'b1;
        tick();
        credit_upd = 1'b0;
        settle();
        chk("t3_tail", grant, 4'b0100);
        chk("t3_tail_type", out_flit_type, T);
        tick();
        put(2, 0, H);
        settle();
        chk("t3_end_cr", credits, 0);
        chk("t3_end_grant", grant, 0);

        // 4: fire + credit_upd together, then overflow
        credit_upd = 1'b1;
        tick();
        credit_upd = 1'b0;
        put(3, 1, H);
        settle();
        chk("t4_alloc", ovr, 1);
        tick();
        credit_upd = 1'b1;
        settle();
        chk("t4_head", grant, 4'b1000);
        tick();
        put(3, 1, T);
        settle();
        chk("t4_cr_hold", credits, 1);
        chk("t4_tail", grant, 4'b1000);
        tick();
        put(3, 0, H);
        settle();
        chk("t4_cr_hold2", credits, 1);
        repeat (3) tick();
        chk("t4_cr_full", credits, 4);
        chk("t4_err0", credit_err, 0);
        tick();
        credit_upd = 1'b0;
        settle();
        chk("t4_err1", credit_err, 1);
        chk("t4_sat", credits, 4);

        // 5: BODY ignored in IDLE; owner drops valid mid-packet
        put(1, 1, B);
        settle();
        chk("t5_body_ovr", ovr, 0);
        tick();
        chk("t5_body_grant", grant, 0);
        put(1, 0, H);
        put(0, 1, H);
        tick();
        settle();
        chk("t5_head", grant, 4'b0001);
        tick();
        put(0, 0, B);
        put(2, 1, H);
        settle();
        chk("t5_gap_fire", flit_fire, 0);
        chk("t5_gap_ovr", ovr, 0);
        tick();
        put(0, 1, B);
        settle();
        chk("t5_body", grant, 4'b0001);
        tick();
        put(0, 1, T);
        settle();
        chk("t5_tail", grant, 4'b0001);
        tick();
        put(0, 0, H);
        settle();
        chk("t5_in2_alloc", ovr, 1);
        tick();
        settle();
        chk("t5_in2_head", grant, 4'b0100);
        chk("t5_in2_sel", out_sel, 2);
        tick();
        chk("t5_cr0", credits, 0);

        // 6: async reset while locked on in2 (rr_ptr=1 before reset)
        put(2, 0, H);
        rstn = 1'b0;
        settle();
        chk("t6_grant", grant, 0);
        chk("t6_fire", flit_fire, 0);
        chk("t6_cr", credits, 4);
        chk("t6_err", credit_err, 0);
        chk("t6_sel", out_sel, 0);
        rstn = 1'b1;
        put(0, 1, H);
        put(1, 1, H);
        settle();
        chk("t6_alloc", ovr, 1);
        tick();
        settle();
        chk("t6_rrptr0", grant, 4'b0001);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
